// File: rtl/line_buf_pkg.sv
// ============================================================================
// Module  : line_buf_pkg
// Brief   : Shared line-buffer constants and line writer FSM state type.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package line_buf_pkg;

    localparam int N_LINES = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } wr_state_t;

    // Rotate a one-hot line select left by one; the top bit wraps to bit 0.
    function automatic logic [N_LINES-1:0] rotl1(input logic [N_LINES-1:0] v);
        return {v[N_LINES-2:0], v[N_LINES-1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wr_ring_ptr.sv
// ============================================================================
// Module  : wr_ring_ptr
// Brief   : One-hot rotating line FIFO write pointer (FIFO 6 wraps to 0).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wr_ring_ptr
    import line_buf_pkg::*;
(
    input  logic               i_clk,
    input  logic               reset,
    input  logic               advance,
    output logic [N_LINES-1:0] ptr
);

    logic [N_LINES-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_ptr <= {{(N_LINES-1){1'b0}}, 1'b1};
        end else if (advance) begin
            r_ptr <= rotl1(r_ptr);
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/line_wr_ctrl.sv
// ============================================================================
// Module  : line_wr_ctrl
// Brief   : Steers received UART pixel bytes into 7 rotating line FIFOs.
//           Optional dropped-byte counter: define LINE_WR_CTRL_DROP_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module line_wr_ctrl
    import line_buf_pkg::*;
#(
    parameter int D_BITS = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               i_drdy,
    input  logic [D_BITS-1:0]  i_data,
    input  logic               i_line_rd_done,
    output logic [N_LINES-1:0] o_wr_en,
    output logic [D_BITS-1:0]  o_data,
    output logic [2:0]         o_lines_avail,
    output logic               o_frame_done,
    output logic               o_overflow
`ifdef LINE_WR_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]        o_drop_cnt
`endif
);

    localparam int              c_col_w      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int              c_row_w      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
    localparam logic [2:0]      c_lines_full = 3'd7;

    logic [c_col_w-1:0] r_col_cnt;
    logic [c_row_w-1:0] r_row_cnt;
    logic [N_LINES-1:0] r_wr_en;
    logic [D_BITS-1:0]  r_data;
    logic               r_line_done;
    logic [2:0]         r_lines_avail;
    logic               r_overflow;
    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic               w_frame_done;

    logic               w_accept;
    logic               w_line_end;
    logic               w_frame_end;
    logic               w_lines_inc;
    logic               w_lines_dec;
    logic [N_LINES-1:0] w_ptr;

    assign w_accept    = i_drdy && (r_lines_avail < c_lines_full);
    assign w_line_end  = w_accept && (r_col_cnt == c_col_last);
    assign w_frame_end = w_line_end && (r_row_cnt == c_row_last);

    // The pointer moves on the last pixel's edge, so that byte still uses the old FIFO.
    wr_ring_ptr u_wr_ring_ptr (
        .i_clk   (i_clk),
        .reset   (reset),
        .advance (w_line_end),
        .ptr     (w_ptr)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_accept) begin
            if (r_col_cnt == c_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= (r_row_cnt == c_row_last) ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_wr_en     <= '0;
            r_data      <= '0;
            r_line_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_en     <= w_accept ? w_ptr : '0;
            r_line_done <= w_line_end;
            if (w_accept) begin
                r_data <= i_data;
            end
            if (i_drdy && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A read that coincides with a line completing cancels it, even from zero.
    assign w_lines_inc = r_line_done;
    assign w_lines_dec = i_line_rd_done && ((r_lines_avail != 3'd0) || w_lines_inc);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_lines_avail <= 3'd0;
        end else begin
            case ({w_lines_inc, w_lines_dec})
                2'b10:   r_lines_avail <= r_lines_avail + 3'd1;
                2'b01:   r_lines_avail <= r_lines_avail - 3'd1;
                default: r_lines_avail <= r_lines_avail;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_frame_end) begin
                    w_state_nxt = DONE;
                end else if (w_accept) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_frame_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_frame_done = 1'b0;
        if (r_state == DONE) begin
            w_frame_done = 1'b1;
        end
    end

`ifdef LINE_WR_CTRL_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_drop_cnt <= 16'd0;
        end else if (i_drdy && !w_accept && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_wr_en       = r_wr_en;
    assign o_data        = r_data;
    assign o_lines_avail = r_lines_avail;
    assign o_frame_done  = w_frame_done;
    assign o_overflow    = r_overflow;

endmodule

`default_nettype wire
